// File: rtl/jvm_param_pusher.sv
// JVM operand push translator: gathers 1..PARAM_BYTES_MAX big-endian operand bytes and
// emits MOV/MVN or MOVW[/MOVT] followed by a pre-indexed STR through a word FIFO.
//
// state        | meaning
// S_IDLE       | waiting for a command, cmd_ready high
// S_GATHER     | shifting operand bytes into the accumulator
// S_EMIT_LO    | writing MOV, MVN or MOVW
// S_EMIT_HI    | writing MOVT for values with a non-zero upper half
// S_EMIT_PUSH  | writing STR Rd,[sp,#-4]!
// S_DONE       | one-cycle done pulse, back to idle

module jvm_param_pusher #(
   parameter int PARAM_BYTES_MAX = 4,
   parameter int OUT_DEPTH       = 4,
   parameter int RD              = 0,
   parameter int CW              = $clog2(PARAM_BYTES_MAX + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [CW-1:0] cmd_count,
   input  logic          cmd_signed,
   input  logic [7:0]    in_byte,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [31:0]   out_inst,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam logic [31:0]   RD_FIELD  = 32'(RD) << 12;
   localparam logic [CW-1:0] MAX_COUNT = CW'(PARAM_BYTES_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GATHER,
      S_EMIT_LO,
      S_EMIT_HI,
      S_EMIT_PUSH,
      S_DONE
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] count_q;
   logic [CW-1:0] remaining_q;
   logic          signed_q;
   logic [31:0]   acc_q;
   logic          err_q;

   logic          accept;
   logic          take_byte;
   logic          cmd_over;
   logic [CW-1:0] clamped_count;

   logic          emit_valid;
   logic [31:0]   emit_word;

   logic [31:0]   ext_mask;
   logic          sign_bit;
   logic [31:0]   value;
   logic [31:0]   value_n;
   logic          is_mov;
   logic          is_mvn;
   logic          needs_hi;
   logic [31:0]   mov_word;
   logic [31:0]   mvn_word;
   logic [31:0]   movw_word;
   logic [31:0]   movt_word;
   logic [31:0]   str_word;
   logic [31:0]   lo_word;

   logic [31:0]   mem_q [OUT_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   occ_q;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   assign cmd_over      = (cmd_count > MAX_COUNT);
   assign clamped_count = cmd_over ? MAX_COUNT : cmd_count;

   // Extension point depends on how many bytes were actually gathered.
   always_comb begin
      ext_mask = 32'hFFFF_FFFF;
      sign_bit = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         if (int'(count_q) == b) begin
            ext_mask = 32'hFFFF_FFFF >> (32 - 8 * b);
            sign_bit = acc_q[8 * b - 1];
         end
      end
      value = (signed_q && sign_bit) ? (acc_q | ~ext_mask) : (acc_q & ext_mask);
   end

   assign value_n  = ~value;
   assign is_mov   = (value[31:8] == 24'd0);
   assign is_mvn   = (value_n[31:8] == 24'd0);
   assign needs_hi = !is_mov && !is_mvn && (value[31:16] != 16'd0);

   assign mov_word  = 32'hE3A0_0000 | RD_FIELD | {24'd0, value[7:0]};
   assign mvn_word  = 32'hE3E0_0000 | RD_FIELD | {24'd0, value_n[7:0]};
   assign movw_word = 32'hE300_0000 | {12'd0, value[15:12], 16'd0} | RD_FIELD | {20'd0, value[11:0]};
   assign movt_word = 32'hE340_0000 | {12'd0, value[31:28], 16'd0} | RD_FIELD | {20'd0, value[27:16]};
   assign str_word  = 32'hE52D_0004 | RD_FIELD;
   assign lo_word   = is_mov ? mov_word : (is_mvn ? mvn_word : movw_word);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      in_ready   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      accept     = 1'b0;
      take_byte  = 1'b0;
      emit_valid = 1'b0;
      emit_word  = 32'd0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = (cmd_count == '0) ? S_DONE : S_GATHER;
            end
         end
         S_GATHER: begin
            in_ready = 1'b1;
            if (in_valid) begin
               take_byte = 1'b1;
               if (remaining_q == CW'(1)) begin
                  state_d = S_EMIT_LO;
               end
            end
         end
         S_EMIT_LO: begin
            emit_valid = 1'b1;
            emit_word  = lo_word;
            if (!fifo_full) begin
               state_d = needs_hi ? S_EMIT_HI : S_EMIT_PUSH;
            end
         end
         S_EMIT_HI: begin
            emit_valid = 1'b1;
            emit_word  = movt_word;
            if (!fifo_full) begin
               state_d = S_EMIT_PUSH;
            end
         end
         S_EMIT_PUSH: begin
            emit_valid = 1'b1;
            emit_word  = str_word;
            if (!fifo_full) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         remaining_q <= '0;
         signed_q    <= 1'b0;
         acc_q       <= 32'd0;
         err_q       <= 1'b0;
      end else if (accept) begin
         count_q     <= clamped_count;
         remaining_q <= clamped_count;
         signed_q    <= cmd_signed;
         acc_q       <= 32'd0;
         if (cmd_over) begin
            err_q <= 1'b1;
         end
      end else if (take_byte) begin
         acc_q       <= {acc_q[23:0], in_byte};
         remaining_q <= remaining_q - CW'(1);
      end
   end

   assign err = err_q;

   // Full is judged on occupancy before any same-cycle pop, so a full FIFO never
   // accepts a write even while the sink is draining it.
   assign fifo_full  = (occ_q == (AW + 1)'(OUT_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign push       = emit_valid && !fifo_full;
   assign pop        = !fifo_empty && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= emit_word;
            wr_ptr_q        <= (wr_ptr_q == AW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == AW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + (AW + 1)'(1);
            2'b01:   occ_q <= occ_q - (AW + 1)'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign out_valid = !fifo_empty;
   assign out_inst  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_jvm_param_pusher.sv
// Bench for jvm_param_pusher: directed scenarios plus randomized back-to-back commands,
// checked against an arithmetic reference of the operand-to-instruction translation.

module tb_jvm_param_pusher;

   localparam int PMAX  = 4;
   localparam int DEPTH = 4;
   localparam int RDN   = 3;
   localparam int CW    = $clog2(PMAX + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [CW-1:0] cmd_count;
   logic          cmd_signed;
   logic [7:0]    in_byte;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   out_inst;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic          err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   bit          rand_ready_en = 1'b0;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   jvm_param_pusher #(
      .PARAM_BYTES_MAX(PMAX),
      .OUT_DEPTH      (DEPTH),
      .RD             (RDN),
      .CW             (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_count (cmd_count),
      .cmd_signed(cmd_signed),
      .in_byte   (in_byte),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_inst  (out_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Sink side: words are recorded at the negedge before the edge that pops them.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_inst);
         if (reset === 1'b0 && done === 1'b1) done_cnt++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: big-endian value, two's-complement reinterpretation, shortest encoding.
   function automatic void model_cmd(input int count, input bit sgn, input logic [7:0] bytes [4]);
      int          n;
      longint      v;
      logic [31:0] val;
      logic [31:0] rdf;
      n = (count > PMAX) ? PMAX : count;
      if (n == 0) return;
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(bytes[i]);
      if (sgn && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
      val = v[31:0];
      rdf = 32'(RDN * 4096);
      if (val <= 32'hFF) begin
         exp_q.push_back(32'hE3A00000 + rdf + val);
      end else if ((~val) <= 32'hFF) begin
         exp_q.push_back(32'hE3E00000 + rdf + (~val));
      end else begin
         exp_q.push_back(32'hE3000000 + ((val / 4096) % 16) * 65536 + rdf + val % 4096);
         if (val / 65536 != 0)
            exp_q.push_back(32'hE3400000 + (val / 268435456) * 65536 + rdf + (val / 65536) % 4096);
      end
      exp_q.push_back(32'hE52D0004 + rdf);
   endfunction

   task automatic run_cmd(input int count, input bit sgn, input logic [7:0] bytes [4],
                          input bit gaps, output bit to);
      int n;
      int w;
      to = 1'b0;
      n  = (count > PMAX) ? PMAX : count;
      model_cmd(count, sgn, bytes);
      w = 0;
      while (cmd_ready !== 1'b1 && w < 500) begin step(); w++; end
      if (cmd_ready !== 1'b1) begin to = 1'b1; return; end
      cmd_valid  = 1'b1;
      cmd_count  = CW'(count);
      cmd_signed = sgn;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) step();
         in_valid = 1'b1;
         in_byte  = bytes[i];
         w = 0;
         while (in_ready !== 1'b1 && w < 500) begin step(); w++; end
         if (in_ready !== 1'b1) begin in_valid = 1'b0; to = 1'b1; return; end
         step();
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain(output bit to);
      int w;
      w = 0;
      while (!(cmd_ready === 1'b1 && out_valid === 1'b0) && w < 2000) begin step(); w++; end
      to = !(cmd_ready === 1'b1 && out_valid === 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 00000000", out_inst); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
   endtask

   task automatic test_single_byte();
      logic [7:0] b [4];
      int k;
      int dc0;
      bit to;
      b = '{8'h05, 8'h00, 8'h00, 8'h00};
      got_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      model_cmd(1, 1'b0, b);
      dc0 = done_cnt;
      cmd_valid = 1'b1; cmd_count = CW'(1); cmd_signed = 1'b0;
      in_valid = 1'b1; in_byte = 8'h05;
      step();
      cmd_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: out_valid %b want 0", out_valid); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_inst !== exp_q[0]) begin
         n_fail++; $display("FAIL single_first_word: got %b/%h want 1/%h", out_valid, out_inst, exp_q[0]);
      end
      k = 3;
      while (cmd_ready !== 1'b1 && k < 50) begin step(); k++; end
      n_checks++; if (k !== 5) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 5", k); end
      wait_drain(to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: drain bound expired"); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (done_cnt - dc0 !== 1) begin n_fail++; $display("FAIL single_done: got %0d pulses want 1", done_cnt - dc0); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
   endtask

   task automatic test_encodings();
      logic [7:0] b [4];
      bit to;
      int dc0;
      got_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      dc0 = done_cnt;
      b = '{8'hFF, 8'hFE, 8'h00, 8'h00};
      run_cmd(2, 1'b1, b, 1'b1, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL enc_mvn_timeout: handshake bound expired"); end
      b = '{8'h12, 8'h34, 8'h56, 8'h78};
      run_cmd(4, 1'b0, b, 1'b1, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL enc_movt_timeout: handshake bound expired"); end
      b = '{8'h80, 8'h00, 8'h00, 8'h00};
      run_cmd(1, 1'b1, b, 1'b0, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL enc_neg_timeout: handshake bound expired"); end
      wait_drain(to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL enc_drain_timeout: drain bound expired"); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL enc_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL enc_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (done_cnt - dc0 !== 3) begin n_fail++; $display("FAIL enc_done: got %0d pulses want 3", done_cnt - dc0); end
   endtask

   task automatic test_stall();
      logic [7:0] b [4];
      bit to;
      got_q.delete(); exp_q.delete();
      out_ready = 1'b0;
      b = '{8'h12, 8'h34, 8'h00, 8'h00};
      run_cmd(2, 1'b0, b, 1'b0, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_cmd1_timeout: handshake bound expired"); end
      b = '{8'h12, 8'h34, 8'h56, 8'h78};
      run_cmd(4, 1'b0, b, 1'b0, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_cmd2_timeout: handshake bound expired"); end
      repeat (12) step();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
      n_checks++; if (out_inst !== exp_q[0]) begin n_fail++; $display("FAIL stall_head: got %h want %h", out_inst, exp_q[0]); end
      out_ready = 1'b1;
      wait_drain(to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_drain_timeout: drain bound expired"); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_count_zero();
      int w;
      got_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 100) begin step(); w++; end
      cmd_valid = 1'b1; cmd_count = CW'(0); cmd_signed = 1'b0;
      step();
      cmd_valid = 1'b0;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid: got %b want 0", out_valid); end
      step();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", done); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL zero_words: got %0d words want 0", got_q.size()); end
   endtask

   task automatic test_clamp();
      logic [7:0] b [4];
      bit to;
      got_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      b[0] = 8'h9C;
      run_cmd(7, 1'b1, b, 1'b0, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL clamp_timeout: handshake bound expired"); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clamp_in_ready: got %b want 0 after 4 bytes", in_ready); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL clamp_err: got %b want 1", err); end
      wait_drain(to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL clamp_drain_timeout: drain bound expired"); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL clamp_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL clamp_err_sticky: got %b want 1", err); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b [4];
      bit to;
      int w;
      got_q.delete(); exp_q.delete();
      out_ready = 1'b0;
      b = '{8'h11, 8'h00, 8'h00, 8'h00};
      run_cmd(1, 1'b0, b, 1'b0, to);
      w = 0;
      while (cmd_ready !== 1'b1 && w < 100) begin step(); w++; end
      cmd_valid = 1'b1; cmd_count = CW'(2); cmd_signed = 1'b0;
      step();
      cmd_valid = 1'b0;
      in_valid = 1'b1; in_byte = 8'hAA;
      step();
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_gathering: in_ready %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_fifo_loaded: out_valid %b want 1", out_valid); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      got_q.delete(); exp_q.delete();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: out_valid %b want 0", out_valid); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err_clear: got %b want 0", err); end
      out_ready = 1'b1;
      b = '{8'h80, 8'h00, 8'h00, 8'h00};
      run_cmd(1, 1'b0, b, 1'b0, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout: handshake bound expired"); end
      wait_drain(to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_drain_timeout: drain bound expired"); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rmid_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [4];
      bit to;
      bit any_to;
      bit any_over;
      int cnt;
      int r;
      int dc0;
      got_q.delete(); exp_q.delete();
      any_to = 1'b0;
      any_over = 1'b0;
      dc0 = done_cnt;
      rand_ready_en = 1'b1;
      for (int c = 0; c < 40; c++) begin
         cnt = $urandom_range(0, 7);
         if (c == 0) cnt = 6;
         if (c == 1) cnt = 0;
         if (cnt > PMAX) any_over = 1'b1;
         for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 3);
            b[i] = (r == 0) ? 8'h00 : ((r == 1) ? 8'hFF : 8'($urandom));
         end
         run_cmd(cnt, 1'($urandom_range(0, 1)), b, 1'b1, to);
         if (to) any_to = 1'b1;
      end
      rand_ready_en = 1'b0;
      step();
      out_ready = 1'b1;
      wait_drain(to);
      n_checks++; if (any_to !== 1'b0 || to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: handshake or drain bound expired"); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (done_cnt - dc0 !== 40) begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 40", done_cnt - dc0); end
      n_checks++; if (err !== any_over) begin n_fail++; $display("FAIL b2b_err: got %b want %b", err, any_over); end
   endtask

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_count  = '0;
      cmd_signed = 1'b0;
      in_byte    = 8'h00;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      test_reset();
      test_single_byte();
      test_encodings();
      test_stall();
      test_count_zero();
      test_clamp();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jvm_param_pusher.md
# jvm_param_pusher

Parametrised successor to the single-byte operand push path of the bytecode-to-ARM translator. It takes JVM operand bytes (1..PARAM_BYTES_MAX, big-endian, signed or unsigned) from the next-byte fetch stream and assembles them into a 32-bit immediate. It then emits the shortest ARM sequence that loads that value into a scratch register and pushes it on the ARM stack. Emitted words pass through an internal instruction FIFO with valid/ready, so the downstream instruction sink can stall without losing words.

## Interface
- PARAM_BYTES_MAX, 4, maximum operand bytes per command (1..4)
- OUT_DEPTH, 4, output FIFO depth in 32-bit words (power of 2, >=2)
- RD, 0, ARM scratch register number (0..12) used as Rd/Rt in every emitted word
- CW, $clog2(PARAM_BYTES_MAX+1), width of cmd_count
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- cmd_valid  in  1  start request
- cmd_ready  out  1  high only in IDLE
- cmd_count  in  CW  operand byte count for this command
- cmd_signed  in  1  1 = sign-extend assembled value, 0 = zero-extend
- in_byte  in  8  operand byte from fetch stream
- in_valid  in  1  in_byte valid
- in_ready  out  1  high only in GATHER
- out_inst  out  32  ARM instruction word at FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  sink accepts out_inst
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the last word of a command has been written to the FIFO
- err  out  1  sticky: cmd_count > PARAM_BYTES_MAX was accepted; cleared only by reset

## Operation
- States: IDLE, GATHER, EMIT_LO, EMIT_HI, EMIT_PUSH, DONE.
- IDLE: when cmd_valid && cmd_ready, latch count (clamped to PARAM_BYTES_MAX; set err if clamped) and signed, clear accumulator. Count 0 goes to DONE. Otherwise go to GATHER.
- GATHER: on each in_valid && in_ready, acc <= {acc[23:0], in_byte} and remaining--. After the last byte, go to EMIT_LO.
- Extension: value = acc sign- or zero-extended from bit 8*count-1 to 32 bits.
- Encoding selection, with Rd = RD<<12:
  - value <= 0xFF: MOV Rd,#v = 0xE3A00000|Rd|v[7:0]. Then EMIT_PUSH.
  - ~value <= 0xFF: MVN Rd,#~v = 0xE3E00000|Rd|(~v)[7:0]. Then EMIT_PUSH.
  - Otherwise: MOVW = 0xE3000000|v[15:12]<<16|Rd|v[11:0]. If v[31:16] != 0, go to EMIT_HI; else go to EMIT_PUSH.
- EMIT_HI: MOVT = 0xE3400000|v[31:28]<<16|Rd|v[27:16].
- EMIT_PUSH: STR Rd,[sp,#-4]! = 0xE52D0004|Rd. Then DONE.
- DONE: done=1 for one cycle, return to IDLE.
- Each EMIT_* state writes exactly one word. It writes only when the FIFO is not full, judged by occupancy before any same-cycle pop. Otherwise it holds state.
- FIFO: circular buffer, pointers wrap mod OUT_DEPTH, occupancy counter 0..OUT_DEPTH. Simultaneous push and pop when not full or empty keeps occupancy unchanged. Pop happens only when out_valid && out_ready.
- FIFO order equals emission order. Words from consecutive commands never interleave.

## Timing
- Reset values: state IDLE, cmd_ready=1, in_ready=0, out_valid=0, out_inst=0x00000000, busy=0, done=0, err=0, FIFO empty, accumulator 0.
- Reset mid-command flushes the FIFO and discards partial operand bytes. cmd_ready=1 the cycle after reset deasserts.
- Command accept at edge N: in_ready=1 from cycle N+1.
- Last byte at edge M: first word written at edge M+1 if the FIFO is not full.
- Word written at edge K: out_valid=1 and out_inst valid from cycle K+1, no combinational bypass.
- Best case (no stalls, 1-byte command): cmd accept, 1 byte, MOV, STR, DONE. That is 5 cycles cmd-to-cmd_ready.
- in_valid gaps stall GATHER with no effect. out_ready low stalls EMIT_* once the FIFO is full.
- done asserts in the cycle after the final FIFO write. For count 0 it asserts in the cycle after accept, with no words written.

## Test plan
- Reset, then cmd count=1 unsigned, byte 0x05 -> FIFO yields 0xE3A00005, 0xE52D0004; done once; busy low after.
- count=2 signed, bytes 0xFF,0xFE (-2) -> 0xE3E00001, 0xE52D0004.
- count=4 unsigned, 0x12,0x34,0x56,0x78 with RD=3 -> 0xE3053678, 0xE3413234, 0xE52D3004.
- count=2 unsigned, 0x12,0x34 with out_ready held low -> stall after OUT_DEPTH words. Release -> 0xE3010234, 0xE52D0004 in order, none lost or duplicated. Also check FIFO wrap across 3 back-to-back commands.
- count=0 -> done one cycle after accept, no words. count=7 with PARAM_BYTES_MAX=4 -> err=1, 4 bytes consumed.
- Assert reset while in GATHER after 1 of 2 bytes -> out_valid=0, cmd_ready=1 next cycle. A following 1-byte command emits correctly.
